// File: rtl/cpu_bus_memory.sv
// cpu_bus_memory: byte-wide data/program memory on the CPU's shared address/data bus.
//
// The CPU drives an address on bus_in with mem_read (data returned combinationally on rdata)
// or mem_write (the data byte follows on bus_in in the next cycle). A host-side byte-stream
// loader fills memory from address 0 while holding the CPU via cpu_hold.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   bus_in                CPU shared bus (address phase or write-data phase)
//   mem_read, mem_write   CPU strobes
//   rdata                 combinational read data (0 when not reading or while loading)
//   ld_start              restart the loader at address 0
//   ld_valid/ld_data      loader byte stream, ld_last marks the final byte
//   ld_ready              loader may transfer (high in the load state)
//   ld_done               one-cycle pulse after the final loader byte
//   cpu_hold              holds the CPU while loading
//   proto_err             sticky bus-protocol error, cleared only by reset
//
// Optional feature: define CPU_BUS_MEMORY_WRPROT_EN to add parameter PROT_TOP; CPU writes to
// addresses <= PROT_TOP are then suppressed and flag proto_err. Loader writes are unaffected.

module cpu_bus_memory #(
  parameter int unsigned ADDR_W = 5
`ifdef CPU_BUS_MEMORY_WRPROT_EN
  ,
  parameter int unsigned PROT_TOP = 15
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_in,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic [7:0] rdata,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       ld_done,
  output logic       cpu_hold,
  output logic       proto_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StWdata, StLoad} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic              ld_done_q, ld_done_d;
  logic              proto_err_q, proto_err_d;
  logic [7:0]        mem_q [Depth];

  // Single write port shared by the CPU data phase and the loader.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [7:0]        mem_wd;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    ld_ptr_d    = ld_ptr_q;
    ld_done_d   = 1'b0;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    mem_wa      = waddr_q;
    mem_wd      = bus_in;

    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          // Loader wins; a concurrent write address phase is dropped.
          state_d  = StLoad;
          ld_ptr_d = '0;
          if (mem_write) proto_err_d = 1'b1;
        end else if (mem_write) begin
          state_d = StWdata;
          waddr_d = bus_in[ADDR_W-1:0];
          if (mem_read) proto_err_d = 1'b1;
        end
      end

      StWdata: begin
        mem_we = 1'b1;
`ifdef CPU_BUS_MEMORY_WRPROT_EN
        if (32'(waddr_q) <= PROT_TOP) begin
          mem_we      = 1'b0;
          proto_err_d = 1'b1;
        end
`endif
        // A strobe here is a protocol violation, not a new address phase.
        if (mem_write) proto_err_d = 1'b1;
        if (ld_start) begin
          state_d  = StLoad;
          ld_ptr_d = '0;
        end else begin
          state_d = StIdle;
        end
      end

      StLoad: begin
        if (ld_start) begin
          ld_ptr_d = '0;
        end else if (ld_valid) begin
          mem_we   = 1'b1;
          mem_wa   = ld_ptr_q;
          mem_wd   = ld_data;
          ld_ptr_d = ld_ptr_q + 1'b1;
          if (ld_last || (ld_ptr_q == {ADDR_W{1'b1}})) begin
            ld_done_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      ld_ptr_q    <= '0;
      ld_done_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_done_q   <= ld_done_d;
      proto_err_q <= proto_err_d;
      if (mem_we) mem_q[mem_wa] <= mem_wd;
    end
  end

  assign rdata     = (mem_read && (state_q != StLoad)) ? mem_q[bus_in[ADDR_W-1:0]] : 8'h00;
  assign ld_ready  = (state_q == StLoad);
  assign cpu_hold  = (state_q == StLoad);
  assign ld_done   = ld_done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Randomized self-checking bench for cpu_bus_memory against a transaction-level model.

module tb_cpu_bus_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] rdata;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       ld_done;
  logic       cpu_hold;
  logic       proto_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: memory contents and sticky error flag.
  logic [7:0] mem_m [32];
  logic       perr_m;

  cpu_bus_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .rdata     (rdata),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .cpu_hold  (cpu_hold),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
    perr_m = 1'b0;
  endtask

  task automatic model_cpu_write(input logic [7:0] a, input logic [7:0] d);
    int idx;
    idx = int'(a) % 32;
`ifdef CPU_BUS_MEMORY_WRPROT_EN
    if (idx <= 15) perr_m = 1'b1;
    else mem_m[idx] = d;
`else
    mem_m[idx] = d;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic cpu_read(input logic [7:0] a);
    bus_in   = a;
    mem_read = 1'b1;
    #1;
    check("rd", rdata, mem_m[int'(a) % 32]);
    cycle();
    mem_read = 1'b0;
  endtask

  // Address phase, data phase (with a concurrent read of the data byte's address, which must
  // see the old contents), then a read of the written address two cycles after the address.
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input bit hold_wr,
                           input bit rd_conf);
    bus_in    = a;
    mem_write = 1'b1;
    mem_read  = rd_conf;
    cycle();
    bus_in    = d;
    mem_write = hold_wr;
    mem_read  = 1'b1;
    #1;
    check("wr_old", rdata, mem_m[int'(d) % 32]);
    cycle();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    model_cpu_write(a, d);
    if (hold_wr || rd_conf) perr_m = 1'b1;
    cpu_read(a);
  endtask

  task automatic load_bytes(input int n, input bit use_last, input bit with_wr);
    ld_start  = 1'b1;
    mem_write = with_wr;
    bus_in    = 8'h09;
    cycle();
    ld_start  = 1'b0;
    mem_write = 1'b0;
    if (with_wr) perr_m = 1'b1;
    check("ld_hold", 8'(cpu_hold), 8'd1);
    check("ld_ready", 8'(ld_ready), 8'd1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        mem_read = 1'b1;
        bus_in   = 8'($urandom);
        #1;
        check("ld_rdata0", rdata, 8'h00);
        check("ld_early_done", 8'(ld_done), 8'd0);
        check("ld_hold_mid", 8'(cpu_hold), 8'd1);
        cycle();
        mem_read = 1'b0;
      end
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      ld_last  = use_last && (i == n - 1);
      mem_m[i] = ld_data;
      cycle();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("ld_done", 8'(ld_done), 8'd1);
    check("ld_hold_fall", 8'(cpu_hold), 8'd0);
    check("ld_ready_fall", 8'(ld_ready), 8'd0);
    // Stray byte after completion must not be accepted.
    ld_valid = 1'b1;
    ld_data  = 8'($urandom);
    cycle();
    ld_valid = 1'b0;
    check("ld_done_pulse", 8'(ld_done), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; bus_in = 8'h00; mem_read = 1'b0; mem_write = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    model_clear();
    do_reset();

    // Reset state.
    bus_in   = 8'h07;
    mem_read = 1'b1;
    #1;
    check("rst_rdata", rdata, 8'h00);
    check("rst_hold", 8'(cpu_hold), 8'd0);
    check("rst_ready", 8'(ld_ready), 8'd0);
    check("rst_done", 8'(ld_done), 8'd0);
    check("rst_perr", 8'(proto_err), 8'd0);
    cycle();
    mem_read = 1'b0;

    // Fixed three-byte program load.
    ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] prog [3];
      prog[0] = 8'h0D; prog[1] = 8'h3E; prog[2] = 8'h42;
      check("prog_hold", 8'(cpu_hold), 8'd1);
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == 2);
      mem_m[i] = prog[i];
      cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("prog_done", 8'(ld_done), 8'd1);
    check("prog_hold_fall", 8'(cpu_hold), 8'd0);
    cycle();
    check("prog_done_once", 8'(ld_done), 8'd0);
    check("prog_m0", mem_m[0], 8'h0D);
    for (int i = 0; i < 3; i++) cpu_read(8'(i));

    // Wrapped address with concurrent old-value read.
    cpu_write(8'h25, 8'hA5, 1'b0, 1'b0);
    check("clean_perr", 8'(proto_err), 8'(perr_m));

    // Full-depth load without ld_last.
    load_bytes(32, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) cpu_read(8'(i));

    // Loader restart mid-stream.
    ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 8'(8'h11 * (i + 1)); mem_m[i] = ld_data;
      cycle();
    end
    ld_start = 1'b1; ld_data = 8'hEE;
    cycle();
    ld_start = 1'b0;
    ld_data = 8'h44; mem_m[0] = 8'h44;
    cycle();
    ld_data = 8'h55; ld_last = 1'b1; mem_m[1] = 8'h55;
    cycle();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("restart_done", 8'(ld_done), 8'd1);
    for (int i = 0; i < 4; i++) cpu_read(8'(i));

    // Reset mid-load aborts, including the byte presented on the reset edge.
    ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h77;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; ld_valid = 1'b0;
    model_clear();
    check("abort_hold", 8'(cpu_hold), 8'd0);
    cpu_read(8'h00);
    cpu_read(8'h02);

    // Write strobe held into the data phase: sticky error.
    cpu_write(8'h1C, 8'h5A, 1'b1, 1'b0);
    check("perr_set", 8'(proto_err), 8'd1);
    cpu_write(8'h1D, 8'h66, 1'b0, 1'b0);
    check("perr_sticky", 8'(proto_err), 8'd1);
    do_reset();
    check("perr_clr", 8'(proto_err), 8'd0);

`ifdef CPU_BUS_MEMORY_WRPROT_EN
    cpu_write(8'h03, 8'hC3, 1'b0, 1'b0);
    check("prot_perr", 8'(proto_err), 8'd1);
    cpu_write(8'h10, 8'hB0, 1'b0, 1'b0);
    load_bytes(4, 1'b1, 1'b0);
    cpu_read(8'h03);
    do_reset();
`endif

    // Randomized transactions.
    for (int it = 0; it < 300; it++) begin
      int op;
      op = int'($urandom_range(19));
      if (op < 7) cpu_write(8'($urandom), 8'($urandom), 1'b0, 1'b0);
      else if (op < 13) cpu_read(8'($urandom));
      else if (op < 15) load_bytes(int'($urandom_range(1, 32)), 1'b1, 1'b0);
      else if (op == 15) cpu_write(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      else if (op == 16) cpu_write(8'($urandom), 8'($urandom), 1'b0, 1'b1);
      else if (op == 17) load_bytes(int'($urandom_range(1, 8)), 1'b1, 1'b1);
      else if (op == 18) load_bytes(32, 1'b0, 1'b0);
      else do_reset();
      check("rand_perr", 8'(proto_err), 8'(perr_m));
    end
    for (int i = 0; i < 32; i++) cpu_read(8'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
